bcd_display_driver: RTL and testbench

Output stage downstream of the processor datapath: captures a 32-bit result value on a one-cycle strobe and converts it to decimal with an iterative shift-add-3 (double-dabble) engine. It then drives the eight active-low seven-segment displays (Display0 = least significant digit) with leading-zero blanking. Values that do not fit in eight decimal digits are shown as an overflow pattern. It sits between the processor's output write path and the board displays, clocked by the processor clock.

---
 rtl/bcd_display_pkg.sv | 32 +++
 rtl/seg7_encoder.sv | 34 +++
 rtl/bcd_display_driver.sv | 158 +++++++++++++++
 tb/tb_bcd_display_driver.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// Shared definitions for the BCD seven-segment display driver.
// Contents:
//   - converter geometry (data width, driven displays, internal BCD digits)
//   - FSM state type
//   - active-low segment patterns, bit order {g,f,e,d,c,b,a}, 0 = lit
package bcd_display_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned DIGITS     = 8;
    // ceil(DATA_WIDTH * log10(2)) digits hold any 32-bit value
    localparam int unsigned BCD_DIGITS = 10;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StLoad
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Ports:
//   bcd_i   - 4-bit BCD digit
//   blank_i - force the display dark (leading-zero blanking)
//   seg_o   - segments {g,f,e,d,c,b,a}, 0 = lit
module seg7_encoder
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                // Non-BCD codes cannot come out of the converter; show a dash if they do.
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Captures a 32-bit unsigned value on a one-cycle strobe, converts it to BCD with an
// iterative shift-add-3 engine (one bit per cycle) and drives eight active-low
// seven-segment displays with leading-zero blanking and an all-dash overflow pattern.
// Ports:
//   clock            - processor clock, rising edge
//   reset            - synchronous active-low reset
//   out_valid        - strobe: out_data holds a new value
//   out_data         - value to display
//   busy             - conversion or display load in progress (registered state)
//   Display0..7      - active-low segments {g,f,e,d,c,b,a}, Display0 = least significant
module bcd_display_driver
    import bcd_display_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  out_valid,
    input  logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic [6:0]            Display0,
    output logic [6:0]            Display1,
    output logic [6:0]            Display2,
    output logic [6:0]            Display3,
    output logic [6:0]            Display4,
    output logic [6:0]            Display5,
    output logic [6:0]            Display6,
    output logic [6:0]            Display7
);

    localparam int unsigned CntW   = $clog2(DATA_WIDTH);
    localparam int unsigned BcdW   = 4 * BCD_DIGITS;
    localparam logic [CntW-1:0] CntMax = CntW'(DATA_WIDTH - 1);

    state_e                        state_q, state_d;
    logic [DATA_WIDTH-1:0]         shift_q, shift_d;
    logic [BcdW-1:0]               bcd_q, bcd_d;
    logic [BcdW-1:0]               bcd_adj;
    logic [CntW-1:0]               cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]         pend_q, pend_d;
    logic                          pend_vld_q, pend_vld_d;
    logic [DIGITS-1:0][6:0]        disp_q, disp_d;
    logic [DIGITS-1:0][6:0]        enc_seg;
    logic [DIGITS-1:0]             blank;
    logic                          overflow;

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // A digit is blank when it and every digit above it are zero; Display0 never blanks.
    always_comb begin
        logic nz_above;
        nz_above = 1'b0;
        blank    = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            nz_above = nz_above | (bcd_q[4*i +: 4] != 4'd0);
            blank[i] = ~nz_above;
        end
    end

    assign overflow = |bcd_q[BcdW-1 : 4*DIGITS];

    for (genvar g = 0; g < int'(DIGITS); g++) begin : gen_enc
        seg7_encoder u_enc (
            .bcd_i   (bcd_q[4*g +: 4]),
            .blank_i (blank[g]),
            .seg_o   (enc_seg[g])
        );
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        disp_d     = disp_q;

        unique case (state_q)
            StIdle: begin
                if (out_valid) begin
                    shift_d = out_data;
                    bcd_d   = '0;
                    cnt_d   = CntMax;
                    state_d = StConvert;
                end
            end

            StConvert: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d            = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StLoad;
                end
                // Last strobe wins; earlier pending values are dropped.
                if (out_valid) begin
                    pend_d     = out_data;
                    pend_vld_d = 1'b1;
                end
            end

            StLoad: begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    disp_d[i] = overflow ? SEG_DASH : enc_seg[i];
                end
                // A strobe in this cycle is newer than any pending value and starts directly.
                if (out_valid || pend_vld_q) begin
                    shift_d    = out_valid ? out_data : pend_q;
                    bcd_d      = '0;
                    cnt_d      = CntMax;
                    pend_vld_d = 1'b0;
                    state_d    = StConvert;
                end else begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            disp_q     <= {{(DIGITS - 1){SEG_BLANK}}, SEG_0};
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            disp_q     <= disp_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign Display0 = disp_q[0];
    assign Display1 = disp_q[1];
    assign Display2 = disp_q[2];
    assign Display3 = disp_q[3];
    assign Display4 = disp_q[4];
    assign Display5 = disp_q[5];
    assign Display6 = disp_q[6];
    assign Display7 = disp_q[7];

endmodule

// File: tb/tb_bcd_display_driver.sv
// Self-checking bench for bcd_display_driver: directed and random values checked
// against a decimal-arithmetic model of what the eight displays should show.
module tb_bcd_display_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        out_valid = 1'b0;
    logic [31:0] out_data = '0;
    logic        busy;
    logic [6:0]  d0, d1, d2, d3, d4, d5, d6, d7;
    logic [55:0] disp_all;

    int tests = 0;
    int fails = 0;
    logic [55:0] cur_disp;

    bcd_display_driver dut (
        .clock     (clock),
        .reset     (reset),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .Display0  (d0),
        .Display1  (d1),
        .Display2  (d2),
        .Display3  (d3),
        .Display4  (d4),
        .Display5  (d5),
        .Display6  (d6),
        .Display7  (d7)
    );

    always #5 clock = ~clock;

    assign disp_all = {d7, d6, d5, d4, d3, d2, d1, d0};

    function automatic logic [6:0] digit_seg(int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Expected {Display7..Display0} for a value, from plain decimal arithmetic.
    function automatic logic [55:0] model(logic [31:0] v);
        longint unsigned val = 64'(v);
        longint unsigned p   = 1;
        logic [55:0]     r   = '0;
        if (val > 64'd99999999) return {8{7'b0111111}};
        for (int i = 0; i < 8; i++) begin
            if (i > 0 && val < p) r[7*i +: 7] = 7'b1111111;
            else                  r[7*i +: 7] = digit_seg(int'((val / p) % 10));
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check_disp(string tag, logic [55:0] exp);
        tests++;
        assert (disp_all === exp) else begin
            fails++;
            $error("FAIL %s: displays observed %h expected %h", tag, disp_all, exp);
        end
    endtask

    task automatic check_busy(string tag, logic exp);
        tests++;
        assert (busy === exp) else begin
            fails++;
            $error("FAIL %s: busy observed %b expected %b", tag, busy, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns one cycle after the display load.
    task automatic run_value(logic [31:0] v);
        out_valid = 1'b1;
        out_data  = v;
        @(negedge clock);
        out_valid = 1'b0;
        check_busy("busy_rise", 1'b1);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clock);
            check_busy("busy_window", k <= 32);
            if (k < 33) check_disp("disp_hold", cur_disp);
            else        check_disp("disp_show", model(v));
        end
        cur_disp = model(v);
    endtask

    initial begin
        logic [31:0] v;
        logic [55:0] exp;

        repeat (3) @(negedge clock);
        check_disp("reset_disp", model(32'd0));
        check_busy("reset_busy", 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_disp("idle_disp", model(32'd0));
        check_busy("idle_busy", 1'b0);
        cur_disp = model(32'd0);

        run_value(32'd0);
        run_value(32'd12345678);
        run_value(32'd907);
        run_value(32'd100000000);
        run_value(32'hFFFFFFFF);
        run_value(32'd99999999);
        run_value(32'd10000000);

        for (int i = 0; i < 12; i++) begin
            case (i % 3)
                0:       v = $urandom;
                1:       v = $urandom_range(99999999, 0);
                default: v = $urandom_range(999, 0);
            endcase
            run_value(v);
        end

        // Strobes during busy: 6 is overwritten by 7 before the first load finishes.
        out_valid = 1'b1;
        out_data  = 32'd5;
        @(negedge clock);
        out_valid = 1'b0;
        for (int k = 1; k <= 68; k++) begin
            if (k == 6) begin
                out_valid = 1'b1;
                out_data  = 32'd6;
            end else if (k == 20) begin
                out_valid = 1'b1;
                out_data  = 32'd7;
            end else begin
                out_valid = 1'b0;
            end
            @(negedge clock);
            check_busy("pend_busy", k <= 65);
            if (k < 33)      exp = cur_disp;
            else if (k < 66) exp = model(32'd5);
            else             exp = model(32'd7);
            check_disp("pend_disp", exp);
        end
        out_valid = 1'b0;
        cur_disp  = model(32'd7);

        // Reset in the middle of a conversion.
        out_valid = 1'b1;
        out_data  = 32'd99999999;
        @(negedge clock);
        out_valid = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_disp("midreset_disp", model(32'd0));
        check_busy("midreset_busy", 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check_busy("postreset_busy", 1'b0);
        cur_disp = model(32'd0);
        run_value(32'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
